// File: rtl/gpio_clkin_monitor.sv
// GPIO clock-input monitor: pin synchroniser, sticky rising-edge flags and per-window edge counters on an Avalon-MM slave.
// Optional interrupt support is compiled in with `define GPIO_CLKIN_IRQ_EN.
module gpio_clkin_monitor #(
    parameter int WIDTH       = 2,
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  pins_in,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [WIDTH-1:0]  sync1;
    logic [WIDTH-1:0]  sync2;
    logic [WIDTH-1:0]  sync3;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  edgecap;
    logic [WIDTH-1:0]  clr_bits;
    logic [3:0]        sel_q;
    logic [31:0]       ctrl_word;
    logic [GATE_W-1:0] gate;
    logic              gate_last;
    logic              wr_en;
    logic              wr_edgecap;
    logic              wr_ctrl;
    logic [CNT_W-1:0]  live      [WIDTH];
    logic [CNT_W-1:0]  live_next [WIDTH];
    logic [CNT_W-1:0]  latched   [WIDTH];
    logic [CNT_W-1:0]  freq_sel;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    // sync2 is the first metastability-safe stage; sync3 only exists to detect rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= pins_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    assign wr_en      = chipselect & ~write_n;
    assign wr_edgecap = wr_en && (address == 2'd1);
    assign wr_ctrl    = wr_en && (address == 2'd2);
    assign clr_bits   = wr_edgecap ? writedata[WIDTH-1:0] : '0;

    // A rise arriving together with a clearing write must not be lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~clr_bits) | rise;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= '0;
        end else if (wr_ctrl) begin
            sel_q <= writedata[3:0];
        end
    end

`ifdef GPIO_CLKIN_IRQ_EN
    logic [WIDTH-1:0] mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (wr_ctrl) begin
            mask_q <= writedata[16 +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edgecap & mask_q);
        end
    end

    always_comb begin
        ctrl_word             = '0;
        ctrl_word[3:0]        = sel_q;
        ctrl_word[16 +: WIDTH] = mask_q;
    end
`else
    assign irq = 1'b0;

    always_comb begin
        ctrl_word      = '0;
        ctrl_word[3:0] = sel_q;
    end
`endif

    assign unused_wdata = ^writedata;

    // Free-running gate; CTRL writes deliberately have no effect on it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate <= '0;
        end else if (gate == GATE_LAST) begin
            gate <= '0;
        end else begin
            gate <= gate + GATE_W'(1);
        end
    end

    assign gate_last = (gate == GATE_LAST);

    always_comb begin
        live_next = live;
        for (int i = 0; i < WIDTH; i++) begin
            if (rise[i] && (live[i] != CNT_MAX)) begin
                live_next[i] = live[i] + CNT_W'(1);
            end
        end
    end

    // The terminal-cycle edge is folded into the closing window via live_next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                live[i]    <= '0;
                latched[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (gate_last) begin
                    latched[i] <= live_next[i];
                    live[i]    <= '0;
                end else begin
                    live[i]    <= live_next[i];
                end
            end
        end
    end

    always_comb begin
        freq_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_q == 4'(i)) begin
                freq_sel = latched[i];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = sync2;
            2'd1:    rd_mux[WIDTH-1:0] = edgecap;
            2'd2:    rd_mux            = ctrl_word;
            default: rd_mux[CNT_W-1:0] = freq_sel;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gpio_clkin_monitor.sv
// Directed bench for gpio_clkin_monitor (WIDTH=2, GATE_CYCLES=100, CNT_W=4); cycle numbers count posedges after reset release.
module tb_gpio_clkin_monitor;

    logic        clk;
    logic        reset_n;
    logic [1:0]  pins_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int half0    = 0;
    int half1    = 0;
    logic [1:0] tog_en;

    gpio_clkin_monitor #(
        .WIDTH       (2),
        .GATE_CYCLES (100),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pins_in    (pins_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // pin0 toggles with period 4, pin1 with period 10 when enabled
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tog_en[0]) begin
            half0++;
            if (half0 == 2) begin
                pins_in[0] = ~pins_in[0];
                half0 = 0;
            end
        end
        if (tog_en[1]) begin
            half1++;
            if (half1 == 5) begin
                pins_in[1] = ~pins_in[1];
                half1 = 0;
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        pins_in    = 2'b00;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tog_en     = 2'b11;

        repeat (3) tick();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick();
            check_output($sformatf("reset_rd%0d", a), readdata, 32'h0);
        end
        check_output("reset_irq", {31'b0, irq}, 32'h0);

        tog_en  = 2'b00;
        pins_in = 2'b00;
        half0   = 0;
        half1   = 0;
        tog_en  = 2'b10;
        reset_n = 1'b1;
        cyc     = 0;

        tick();
        bus_write(2'd2, 32'h1);
        address = 2'd2;
        tick();
        check_output("ctrl_sel1", readdata, 32'h1);
        address = 2'd3;

        wait_until(100);
        check_output("freq_before_first", readdata, 32'h0);
        tick();
        check_output("freq_win1", readdata, 32'd10);
        wait_until(201);
        check_output("freq_win2", readdata, 32'd10);

        wait_until(210);
        pins_in[0] = 1'b1;
        address    = 2'd0;
        tick();
        tick();
        check_output("data_b0_t2", {31'b0, readdata[0]}, 32'h0);
        tick();
        check_output("data_b0_t3", {31'b0, readdata[0]}, 32'h1);
        address = 2'd1;
        tick();
        check_output("edgecap_both", readdata, 32'h3);

        bus_write(2'd1, 32'h1);
        address = 2'd1;
        tick();
        check_output("w1c_clear", {31'b0, readdata[0]}, 32'h0);

        pins_in[0] = 1'b0;
        wait_until(220);
        pins_in[0] = 1'b1;
        tick();
        tick();
        bus_write(2'd1, 32'h1);
        address = 2'd1;
        tick();
        check_output("w1c_edge_wins", {31'b0, readdata[0]}, 32'h1);
        bus_write(2'd1, 32'h1);
        address = 2'd1;
        tick();
        check_output("w1c_no_edge", {31'b0, readdata[0]}, 32'h0);

        bus_write(2'd2, 32'h0);
        address = 2'd3;
        wait_until(301);
        check_output("freq_ch0_two", readdata, 32'd2);
        wait_until(401);
        check_output("freq_ch0_static", readdata, 32'd0);

        bus_write(2'd2, 32'h5);
        address = 2'd3;
        tick();
        check_output("freq_sel5", readdata, 32'd0);

        bus_write(2'd2, 32'h0);
        address   = 2'd3;
        half0     = 0;
        tog_en[0] = 1'b1;
        wait_until(501);
        check_output("freq_sat_w5", readdata, 32'd15);
        wait_until(590);
        tog_en[0]  = 1'b0;
        pins_in[0] = 1'b0;
        wait_until(601);
        check_output("freq_sat_w6", readdata, 32'd15);

        wait_until(697);
        pins_in[0] = 1'b1;
        wait_until(701);
        check_output("term_edge_closing", readdata, 32'd1);
        pins_in[0] = 1'b0;
        wait_until(798);
        pins_in[0] = 1'b1;
        wait_until(801);
        check_output("after_term_empty", readdata, 32'd0);
        wait_until(901);
        check_output("after_term_next", readdata, 32'd1);

        tog_en  = 2'b00;
        pins_in = 2'b00;
        repeat (5) tick();
`ifdef GPIO_CLKIN_IRQ_EN
        bus_write(2'd2, 32'h0002_0000);
        bus_write(2'd1, 32'h3);
        tick();
        check_output("irq_idle", {31'b0, irq}, 32'h0);
        address = 2'd2;
        tick();
        check_output("ctrl_mask_rd", readdata, 32'h0002_0000);

        pins_in[0] = 1'b1;
        repeat (5) tick();
        check_output("irq_ch0_masked", {31'b0, irq}, 32'h0);

        pins_in[1] = 1'b1;
        repeat (3) tick();
        check_output("irq_before", {31'b0, irq}, 32'h0);
        tick();
        check_output("irq_set", {31'b0, irq}, 32'h1);

        bus_write(2'd1, 32'h2);
        check_output("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        check_output("irq_cleared", {31'b0, irq}, 32'h0);
`else
        bus_write(2'd2, 32'hFFFF_0003);
        address = 2'd2;
        tick();
        check_output("ctrl_no_mask", readdata, 32'h3);
        pins_in[1] = 1'b1;
        repeat (5) tick();
        check_output("irq_tied_low", {31'b0, irq}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
